// File: rtl/cpu_pkg.sv
// Shared ARM32 core definitions: memory geometry defaults, arbiter tuning and
// the pending-read owner encoding used by the memory arbiter.
package cpu_pkg;

  localparam int CPU_ADDR_W     = 12;
  localparam int CPU_DATA_W     = 32;
  localparam int CPU_STARVE_LIM = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } rd_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store data.
// Data wins by default; a saturating wait counter bounds fetch starvation.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter int DATA_W     = CPU_DATA_W,
  parameter int STARVE_LIM = CPU_STARVE_LIM
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,

  output logic                ram_en,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_be,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM_C = CNT_W'(STARVE_LIM);

  rd_owner_t        rd_owner;
  logic [CNT_W-1:0] starve_cnt;
  logic             fetch_prio;

  // NOTE: every signal written here gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    fetch_prio = (starve_cnt == LIM_C);
    // Grants are masked while in reset so nothing reaches the RAM.
    if_gnt     = reset_n && if_req && (fetch_prio || !d_req);
    d_gnt      = reset_n && d_req && !if_gnt;

    ram_en    = if_gnt || d_gnt;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (if_gnt) begin
      ram_be   = {BE_W{1'b1}};
      ram_addr = if_addr;
    end else if (d_gnt) begin
      ram_we    = d_we;
      ram_be    = d_be;
      ram_addr  = d_addr;
      ram_wdata = d_wdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_owner   <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      if (if_gnt)                rd_owner <= OWN_IF;
      else if (d_gnt && !d_we)   rd_owner <= OWN_D;
      else                       rd_owner <= OWN_NONE;

      if (if_req && !if_gnt) begin
        if (starve_cnt != LIM_C) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // rvalid is masked during reset so a read granted just before reset is dropped.
  assign if_rvalid = reset_n && (rd_owner == OWN_IF);
  assign d_rvalid  = reset_n && (rd_owner == OWN_D);
  assign if_rdata  = ram_rdata;
  assign d_rdata   = ram_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the ARM32 core. Shares one synchronous word-addressed RAM (4096 x 32) between the instruction-fetch path and the load/store data path. It grants at most one access per cycle, routes the one-cycle-latency read data back to the winning requester, and bounds fetch starvation with a saturating wait counter. It sits between the `processor` fetch/execute logic and the `ram` instance.

## Interface
Parameters:
- `ADDR_W`, 12: word-address width (RAM depth = 2^ADDR_W).
- `DATA_W`, 32: data width.
- `STARVE_LIM`, 4: consecutive denied fetch cycles after which fetch wins over data.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `if_req`  in  1  fetch read request; held until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch word address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  `if_rdata` valid.
- `if_rdata`  out  DATA_W  fetched instruction.
- `d_req`  in  1  data request; held until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_be`  in  DATA_W/8  byte enables for stores.
- `d_addr`  in  ADDR_W  data word address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  `d_rdata` valid (loads only).
- `d_rdata`  out  DATA_W  load data.
- `ram_en`, `ram_we`  out  1 each  RAM access / write strobe.
- `ram_be`  out  DATA_W/8  RAM byte enables.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data, valid the cycle after a read `ram_en`.

## Operation
- Grant decision is combinational from `if_req`, `d_req` and the registered state. At most one of `if_gnt`/`d_gnt` is high per cycle.
- Priority: data wins by default. Fetch wins when `if_req` is high and `starve_cnt == STARVE_LIM`.
- `starve_cnt`: 0 at reset. It increments (saturating at STARVE_LIM) each cycle `if_req && !if_gnt`. It clears on `if_gnt` or `!if_req`.
- On a grant, the winner's address/data/we/be drive the RAM port and `ram_en=1`. With no grant, `ram_en=0`, `ram_we=0`, and other RAM outputs are don't-care (drive 0).
- Fetch is always a read: `ram_we=0`, `ram_be` all ones.
- Pending-read register `rd_owner` takes one of {NONE, IF, D}. It is set on a granted read (fetch, or data with `d_we=0`), and NONE otherwise, including for stores.
- When `rd_owner` is IF/D, the matching `*_rvalid` is 1 and `*_rdata = ram_rdata`. Both rdata outputs pass `ram_rdata` through unconditionally; only `rvalid` qualifies them.
- Stores complete at `d_gnt`; no `d_rvalid` is issued.
- Addresses are ADDR_W bits; there is no range check. Wrap is inherent.

## Timing
- Reset values: `rd_owner`=NONE and `starve_cnt`=0. All `*_gnt`, `*_rvalid`, `ram_en` and `ram_we` read 0 while `reset_n`=0, since grants are masked during reset.
- Grant latency is 0 cycles (same cycle as request, if it wins). Read data latency is exactly 1 cycle after the grant.
- Back-to-back grants are allowed every cycle. Example: D granted at cycle n, IF at n+1 gives `d_rvalid` at n+1 and `if_rvalid` at n+2.
- Simultaneous requests with `starve_cnt<STARVE_LIM` grant D. IF is then granted at the latest on the (STARVE_LIM+1)-th cycle of continuous request.
- A requester must hold `req`/`addr`/`wdata`/`we`/`be` stable until its `gnt`. A request dropped before grant is simply lost, with no side effects.
- Reset asserted mid-operation: a read granted in the cycle before reset produces no `rvalid`, because `rd_owner` clears synchronously.

## Structure
- Shared package `cpu_pkg`:
  - `ADDR_W`/`DATA_W` defaults;
  - enum `rd_owner_t` {OWN_NONE, OWN_IF, OWN_D};
  - `STARVE_LIM` default.
- Single module with no sub-module. The `starve_cnt` is a few lines of logic inline. The RAM remains the existing `ram` instance, outside this block.

## Test plan
- **Fetch only.** Reset, then `if_req` with `if_addr`=0x000..0x003 over consecutive cycles, RAM preloaded with 0xE3A00001+i. Required: `if_gnt` each cycle, and `if_rvalid`+`if_rdata`=0xE3A00001+i one cycle later.
- **Load/store mix.** Store 0xDEADBEEF to 0x010 with `d_be`=4'b1111, then load 0x010. Required: store gives `d_gnt` and no `d_rvalid`; load gives `d_rvalid`=1, `d_rdata`=0xDEADBEEF next cycle. Then store `d_be`=4'b0001 data 0x000000AA and reload: required 0xDEADBEAA.
- **Conflict and starvation.** `if_req` and `d_req` high continuously for 6 cycles, STARVE_LIM=4. Required grant sequence: D,D,D,D,IF,D, with `starve_cnt` clearing after the IF grant.
- **Routing.** D granted at cycle n, IF at n+1. Required: only `d_rvalid` at n+1, only `if_rvalid` at n+2, with no overlap.
- **Reset mid-read.** Grant a fetch, then assert `reset_n`=0 the next cycle. Required: `if_rvalid`=0, all grants 0 during reset, and `starve_cnt`=0 after release.
- **Address wrap.** Fetch from 0xFFF, then 0x000. Required: correct data from both ends of the RAM with no X propagation.
